// File: rtl/register_bank_2r1w.sv
`timescale 1ns/1ps
// register_bank_2r1w
// Architectural register file with two registered read ports, one write
// port with byte enables, and a per-register pending scoreboard.
// Each read sees the state as it will be after this cycle's write and
// pending update. Register data and the pending bit therefore both
// reflect any write or pend_set to the same address in the same cycle.
module register_bank_2r1w #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int ZERO_R0 = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_req_a,
  input  logic [ADDR_W-1:0]     rd_addr_a,
  output logic [DATA_W-1:0]     rd_data_a,
  output logic                  rd_pend_a,
  output logic                  rd_vld_a,
  input  logic                  rd_req_b,
  input  logic [ADDR_W-1:0]     rd_addr_b,
  output logic [DATA_W-1:0]     rd_data_b,
  output logic                  rd_pend_b,
  output logic                  rd_vld_b,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic                  pend_set,
  input  logic [ADDR_W-1:0]     pend_addr,
  output logic [(1<<ADDR_W)-1:0] pend_vec
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;

  logic              wr_ok;
  logic              pset_ok;
  logic [DATA_W-1:0] wr_merged;

  logic [DATA_W-1:0] rd_data_a_q, rd_data_a_d;
  logic [DATA_W-1:0] rd_data_b_q, rd_data_b_d;
  logic              rd_pend_a_q, rd_pend_a_d;
  logic              rd_pend_b_q, rd_pend_b_d;
  logic              rd_vld_a_q, rd_vld_b_q;

  // Qualify write and pend_set; a hardwired-zero r0 swallows both.
  always_comb begin
    wr_ok   = wr_en;
    pset_ok = pend_set;
    if (ZERO_R0 != 0) begin
      if (wr_addr == '0)   wr_ok   = 1'b0;
      if (pend_addr == '0) pset_ok = 1'b0;
    end
  end

  // Post-write value of the target register: new bytes where enabled.
  always_comb begin
    wr_merged = mem_q[wr_addr];
    for (int i = 0; i < NB; i++) begin
      if (wr_be[i]) wr_merged[8*i +: 8] = wr_data[8*i +: 8];
    end
  end

  // Scoreboard next state: the write clears, then pend_set wins.
  always_comb begin
    pend_d = pend_q;
    if (wr_ok)   pend_d[wr_addr]   = 1'b0;
    if (pset_ok) pend_d[pend_addr] = 1'b1;
  end

  // Read-port next values with write-first bypass of the merged word.
  always_comb begin
    rd_data_a_d = mem_q[rd_addr_a];
    rd_data_b_d = mem_q[rd_addr_b];
    if (wr_ok && (wr_addr == rd_addr_a)) rd_data_a_d = wr_merged;
    if (wr_ok && (wr_addr == rd_addr_b)) rd_data_b_d = wr_merged;
    rd_pend_a_d = pend_d[rd_addr_a];
    rd_pend_b_d = pend_d[rd_addr_b];
  end

  // Register storage; r0 is never written when hardwired to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_addr] <= wr_merged;
    end
  end

  // Pending scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  // Read output registers: data/pend load on request and hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
      rd_pend_a_q <= 1'b0;
      rd_pend_b_q <= 1'b0;
      rd_vld_a_q  <= 1'b0;
      rd_vld_b_q  <= 1'b0;
    end else begin
      rd_vld_a_q <= rd_req_a;
      rd_vld_b_q <= rd_req_b;
      if (rd_req_a) begin
        rd_data_a_q <= rd_data_a_d;
        rd_pend_a_q <= rd_pend_a_d;
      end
      if (rd_req_b) begin
        rd_data_b_q <= rd_data_b_d;
        rd_pend_b_q <= rd_pend_b_d;
      end
    end
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_pend_a = rd_pend_a_q;
  assign rd_vld_a  = rd_vld_a_q;
  assign rd_data_b = rd_data_b_q;
  assign rd_pend_b = rd_pend_b_q;
  assign rd_vld_b  = rd_vld_b_q;
  assign pend_vec  = pend_q;

endmodule

// File: tb/tb_register_bank_2r1w.sv
`timescale 1ns/1ps
// Bench for register_bank_2r1w. Three instances: 32x16 plain, 32x16 with
// hardwired r0 (both driven by group 0), and 16x8 plain (group 1, random).
module tb_register_bank_2r1w;

  logic clk;
  logic rst_n;

  // stimulus, indexed [group] and [group][port]
  logic        rreq  [2][2];
  logic [3:0]  raddr [2][2];
  logic        wen   [2];
  logic [3:0]  waddr [2];
  logic [31:0] wdata [2];
  logic [3:0]  wbe   [2];
  logic        pset  [2];
  logic [3:0]  paddr [2];

  // observed outputs, indexed [instance][port]
  logic [31:0] o_data [3][2];
  logic        o_pend [3][2];
  logic        o_vld  [3][2];
  logic [15:0] o_pv   [3];
  logic [15:0] d2_a, d2_b;
  logic [7:0]  pv2;

  int n_chk  = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  register_bank_2r1w #(.DATA_W(32), .ADDR_W(4), .ZERO_R0(0)) u0 (
    .clk(clk), .rst_n(rst_n),
    .rd_req_a(rreq[0][0]), .rd_addr_a(raddr[0][0]), .rd_data_a(o_data[0][0]),
    .rd_pend_a(o_pend[0][0]), .rd_vld_a(o_vld[0][0]),
    .rd_req_b(rreq[0][1]), .rd_addr_b(raddr[0][1]), .rd_data_b(o_data[0][1]),
    .rd_pend_b(o_pend[0][1]), .rd_vld_b(o_vld[0][1]),
    .wr_en(wen[0]), .wr_addr(waddr[0]), .wr_data(wdata[0]), .wr_be(wbe[0]),
    .pend_set(pset[0]), .pend_addr(paddr[0]), .pend_vec(o_pv[0]));

  register_bank_2r1w #(.DATA_W(32), .ADDR_W(4), .ZERO_R0(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .rd_req_a(rreq[0][0]), .rd_addr_a(raddr[0][0]), .rd_data_a(o_data[1][0]),
    .rd_pend_a(o_pend[1][0]), .rd_vld_a(o_vld[1][0]),
    .rd_req_b(rreq[0][1]), .rd_addr_b(raddr[0][1]), .rd_data_b(o_data[1][1]),
    .rd_pend_b(o_pend[1][1]), .rd_vld_b(o_vld[1][1]),
    .wr_en(wen[0]), .wr_addr(waddr[0]), .wr_data(wdata[0]), .wr_be(wbe[0]),
    .pend_set(pset[0]), .pend_addr(paddr[0]), .pend_vec(o_pv[1]));

  register_bank_2r1w #(.DATA_W(16), .ADDR_W(3), .ZERO_R0(0)) u2 (
    .clk(clk), .rst_n(rst_n),
    .rd_req_a(rreq[1][0]), .rd_addr_a(raddr[1][0][2:0]), .rd_data_a(d2_a),
    .rd_pend_a(o_pend[2][0]), .rd_vld_a(o_vld[2][0]),
    .rd_req_b(rreq[1][1]), .rd_addr_b(raddr[1][1][2:0]), .rd_data_b(d2_b),
    .rd_pend_b(o_pend[2][1]), .rd_vld_b(o_vld[2][1]),
    .wr_en(wen[1]), .wr_addr(waddr[1][2:0]), .wr_data(wdata[1][15:0]), .wr_be(wbe[1][1:0]),
    .pend_set(pset[1]), .pend_addr(paddr[1][2:0]), .pend_vec(pv2));

  assign o_data[2][0] = {16'h0, d2_a};
  assign o_data[2][1] = {16'h0, d2_b};
  assign o_pv[2]      = {8'h0, pv2};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_mem  [3][16];
  logic [15:0] m_pend [3];
  logic [31:0] e_data [3][2];
  logic        e_pend [3][2];
  logic        e_vld  [3][2];
  int          g, nb;
  bit          z;
  logic [3:0]  am, wa, pa, ra;

  // Apply each edge's write, then pend ops, then serve reads from the
  // resulting state; compare every output shortly after the edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        for (int r = 0; r < 16; r++) m_mem[k][r] = 32'h0;
        m_pend[k] = 16'h0;
        for (int p = 0; p < 2; p++) begin
          e_data[k][p] = 32'h0;
          e_pend[k][p] = 1'b0;
          e_vld[k][p]  = 1'b0;
        end
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        g  = (k == 2) ? 1 : 0;
        z  = (k == 1);
        nb = (k == 2) ? 2 : 4;
        am = (k == 2) ? 4'd7 : 4'd15;
        wa = waddr[g] & am;
        pa = paddr[g] & am;
        if (wen[g] && !(z && wa == 4'd0)) begin
          for (int i = 0; i < nb; i++)
            if (wbe[g][i]) m_mem[k][wa][8*i +: 8] = wdata[g][8*i +: 8];
          m_pend[k][wa] = 1'b0;
        end
        if (pset[g] && !(z && pa == 4'd0)) m_pend[k][pa] = 1'b1;
        for (int p = 0; p < 2; p++) begin
          ra = raddr[g][p] & am;
          e_vld[k][p] = rreq[g][p];
          if (rreq[g][p]) begin
            e_data[k][p] = m_mem[k][ra];
            e_pend[k][p] = m_pend[k][ra];
          end
        end
      end
      #1;
      for (int k = 0; k < 3; k++) begin
        for (int p = 0; p < 2; p++) begin
          chk($sformatf("u%0d data%0d", k, p), o_data[k][p], e_data[k][p]);
          chk($sformatf("u%0d pend%0d", k, p), {31'h0, o_pend[k][p]}, {31'h0, e_pend[k][p]});
          chk($sformatf("u%0d vld%0d", k, p), {31'h0, o_vld[k][p]}, {31'h0, e_vld[k][p]});
        end
        chk($sformatf("u%0d pend_vec", k), {16'h0, o_pv[k]}, {16'h0, m_pend[k]});
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic idle();
    for (int gg = 0; gg < 2; gg++) begin
      wen[gg] = 1'b0; waddr[gg] = 4'h0; wdata[gg] = 32'h0; wbe[gg] = 4'h0;
      pset[gg] = 1'b0; paddr[gg] = 4'h0;
      for (int p = 0; p < 2; p++) begin
        rreq[gg][p] = 1'b0; raddr[gg][p] = 4'h0;
      end
    end
  endtask

  task automatic wr0(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    wen[0] = 1'b1; waddr[0] = a; wdata[0] = d; wbe[0] = be;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    chk("rst data_a", o_data[0][0], 32'h0);
    chk("rst vld_a", {31'h0, o_vld[0][0]}, 32'h0);
    chk("rst pend_vec", {16'h0, o_pv[0]}, 32'h0);
    rst_n = 1'b1;

    // traffic before the async reset
    wr0(4'd1, 32'h0000_1234, 4'hF);
    pset[0] = 1'b1; paddr[0] = 4'd2;
    rreq[0][0] = 1'b1; raddr[0][0] = 4'd1;
    rreq[0][1] = 1'b1; raddr[0][1] = 4'd2;
    @(negedge clk); idle();
    chk("pre data_a", o_data[0][0], 32'h0000_1234);
    chk("pre pend_b", {31'h0, o_pend[0][1]}, 32'h1);
    chk("pre pend_vec", {16'h0, o_pv[0]}, 32'h0000_0004);
    #2 rst_n = 1'b0;
    #1;
    chk("async data_a", o_data[0][0], 32'h0);
    chk("async vld_a", {31'h0, o_vld[0][0]}, 32'h0);
    chk("async pend_b", {31'h0, o_pend[0][1]}, 32'h0);
    chk("async pend_vec", {16'h0, o_pv[0]}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rreq[0][0] = 1'b1; raddr[0][0] = 4'd5;
    @(negedge clk); idle();
    chk("r5 data", o_data[0][0], 32'h0);
    chk("r5 pend", {31'h0, o_pend[0][0]}, 32'h0);
    chk("r5 vld", {31'h0, o_vld[0][0]}, 32'h1);
    chk("r1 cleared", m_mem[0][1], 32'h0);

    // byte enables
    wr0(4'd3, 32'hAABB_CCDD, 4'hF);
    @(negedge clk); idle();
    wr0(4'd3, 32'h1122_3344, 4'b0101);
    @(negedge clk); idle();
    rreq[0][0] = 1'b1; raddr[0][0] = 4'd3;
    @(negedge clk); idle();
    chk("be r3", o_data[0][0], 32'hAA22_CC44);

    // bypass on both ports
    wr0(4'd7, 32'hDEAD_BEEF, 4'hF);
    rreq[0][0] = 1'b1; raddr[0][0] = 4'd7;
    rreq[0][1] = 1'b1; raddr[0][1] = 4'd7;
    @(negedge clk); idle();
    chk("byp data_a", o_data[0][0], 32'hDEAD_BEEF);
    chk("byp data_b", o_data[0][1], 32'hDEAD_BEEF);
    chk("byp vld_a", {31'h0, o_vld[0][0]}, 32'h1);
    chk("byp vld_b", {31'h0, o_vld[0][1]}, 32'h1);

    // scoreboard
    pset[0] = 1'b1; paddr[0] = 4'd9;
    @(negedge clk); idle();
    chk("sb set", {31'h0, o_pv[0][9]}, 32'h1);
    rreq[0][0] = 1'b1; raddr[0][0] = 4'd9;
    @(negedge clk); idle();
    chk("sb rd_pend", {31'h0, o_pend[0][0]}, 32'h1);
    wr0(4'd9, 32'h5, 4'hF);
    rreq[0][0] = 1'b1; raddr[0][0] = 4'd9;
    @(negedge clk); idle();
    chk("sb clr data", o_data[0][0], 32'h5);
    chk("sb clr pend", {31'h0, o_pend[0][0]}, 32'h0);
    chk("sb clr vec", {31'h0, o_pv[0][9]}, 32'h0);
    wr0(4'd9, 32'h77, 4'hF);
    pset[0] = 1'b1; paddr[0] = 4'd9;
    @(negedge clk); idle();
    chk("sb setwins vec", {31'h0, o_pv[0][9]}, 32'h1);
    rreq[0][0] = 1'b1; raddr[0][0] = 4'd9;
    @(negedge clk); idle();
    chk("sb setwins data", o_data[0][0], 32'h77);
    chk("sb setwins pend", {31'h0, o_pend[0][0]}, 32'h1);

    // register 0, plain vs hardwired
    wr0(4'd0, 32'hFFFF_FFFF, 4'hF);
    pset[0] = 1'b1; paddr[0] = 4'd0;
    @(negedge clk); idle();
    rreq[0][0] = 1'b1; raddr[0][0] = 4'd0;
    rreq[0][1] = 1'b1; raddr[0][1] = 4'd0;
    @(negedge clk); idle();
    chk("r0 plain data", o_data[0][0], 32'hFFFF_FFFF);
    chk("r0 plain pend", {31'h0, o_pend[0][1]}, 32'h1);
    chk("r0 plain vec", {31'h0, o_pv[0][0]}, 32'h1);
    chk("r0 zero data", o_data[1][0], 32'h0);
    chk("r0 zero pend", {31'h0, o_pend[1][1]}, 32'h0);
    chk("r0 zero vec", {31'h0, o_pv[1][0]}, 32'h0);

    // random traffic on all instances
    for (int c = 0; c < 10000; c++) begin
      for (int gg = 0; gg < 2; gg++) begin
        wen[gg]   = ($urandom_range(0, 1) == 1);
        waddr[gg] = 4'($urandom_range(0, gg == 1 ? 7 : 15));
        wdata[gg] = $urandom;
        wbe[gg]   = 4'($urandom_range(0, 15));
        pset[gg]  = ($urandom_range(0, 3) == 0);
        paddr[gg] = 4'($urandom_range(0, gg == 1 ? 7 : 15));
        for (int p = 0; p < 2; p++) begin
          rreq[gg][p]  = ($urandom_range(0, 2) != 0);
          raddr[gg][p] = 4'($urandom_range(0, gg == 1 ? 7 : 15));
        end
      end
      @(negedge clk);
    end
    idle();

    // fill all 8 registers of the narrow bank, read both extremes
    for (int i = 0; i < 8; i++) begin
      wen[1] = 1'b1; waddr[1] = 4'(i); wdata[1] = 32'h0000_A0A0 + i; wbe[1] = 4'h3;
      @(negedge clk);
    end
    idle();
    rreq[1][0] = 1'b1; raddr[1][0] = 4'd0;
    rreq[1][1] = 1'b1; raddr[1][1] = 4'd7;
    @(negedge clk); idle();
    chk("w16 r0", o_data[2][0], 32'h0000_A0A0);
    chk("w16 r7", o_data[2][1], 32'h0000_A0A7);
    chk("w16 pend r0", {31'h0, o_pend[2][0]}, 32'h0);
    chk("w16 pend r7", {31'h0, o_pend[2][1]}, 32'h0);
    chk("w16 pend_vec", {16'h0, o_pv[2]}, 32'h0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
